lfsr_multi_stage: RTL and testbench
===================================

Name: lfsr_multi_stage

Overview:
- 32-bit Fibonacci LFSR that advances one shift per clock through a multi-cycle block of STEPS shifts.
- Seeded once after reset.
- Publishes the state reached at the end of each block on lfsr_out, then keeps free-running from that state.
- Sits as a standalone pseudo-random source in the lab/UDM test designs.

Parameters:
- WIDTH, 32: LFSR and seed/output width.
- STEPS, 32: shifts per output block; counter width is clog2(STEPS) (5 bits).
- TAPS, 32'h80200003: feedback tap mask, polynomial x^32+x^22+x^2+x+1 (bits 31, 21, 1, 0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset; one clock domain only.
- seed  in  WIDTH  initial LFSR value, sampled only in LOAD.
- lfsr_out  out  WIDTH  registered state after each completed block of STEPS shifts.

Behaviour:
- Internal signals named exactly counter (5-bit reg), feedback (1-bit comb), current_state (WIDTH reg); benches probe them hierarchically.
- feedback = XOR reduction of (current_state & TAPS), purely combinational.
- next_state = {current_state[WIDTH-2:0], feedback}.
- FSM with 2 states, LOAD and RUN.
- rst low, asynchronously: state=LOAD, current_state=0, counter=0, lfsr_out=0.
- LOAD, first rising edge after rst high:
  - current_state<=seed (zero-guard rule below); counter<=0; state<=RUN.
  - lfsr_out holds its value; no shift occurs.
- RUN, every rising edge:
  - current_state<=next_state; counter<=counter+1.
  - When counter==STEPS-1: lfsr_out<=next_state, counter<=0 (wrap).
  - Shifting continues from the current state; no reseed.
- Latency:
  - First lfsr_out update lands at the 33rd rising edge after reset release (1 load edge + 32 shift edges).
  - Further updates every 32 edges.
- lfsr_out changes only on block completion; otherwise stable.
- seed changes after LOAD are ignored until the next reset.
- Reset mid-block: all registers clear immediately regardless of counter; a new load follows release.
- State value 0 is a lock-up state: it stays 0 forever unless the zero guard is compiled in.
- No handshake; the output is always readable.

Optional Feature:
- Macro LFSR_ZERO_GUARD_EN.
- Defined: in LOAD, if seed==0, current_state<=1 so the LFSR never locks up.
- Undefined: seed is loaded verbatim; a zero seed gives current_state=0, feedback=0, and lfsr_out=0 forever.

Test Plan:
- Reset then seed: rst low 10 ns, seed=32'h1234FADC, release. Required:
  - after load edge: current_state=1234FADC, counter=0;
  - next edge: feedback was 1, current_state=2469F5B9, counter=1;
  - next edge: 48D3EB72, counter=2.
- Block output: same run, compare lfsr_out against a bit-accurate software model.
  - lfsr_out=0 until edge 33.
  - Then equals model state after 32 shifts; counter returns to 0 on that edge.
  - Next update at edge 65.
- Seed 32'h00000001: state sequence 00000001, 00000003, 00000006, 0000000D on successive edges.
- Zero seed:
  - with LFSR_ZERO_GUARD_EN: loads 00000001, same sequence as the previous scenario;
  - without it: current_state and lfsr_out stay 0 for 100 cycles.
- Async reset mid-block: assert rst low between edges while counter=10. Required:
  - counter, current_state, and lfsr_out read 0 before the next clock edge;
  - after release, seed is reloaded and counting restarts.
- Seed change ignored: change seed to DEADBEEF after the load edge. The state sequence must be unchanged versus the first scenario.

Source files
------------

// File: rtl/lfsr_multi_stage.sv
// 32-bit Fibonacci LFSR. It is seeded once after reset, then shifts once per clock and publishes its state after every STEPS shifts.
// Optional macro LFSR_ZERO_GUARD_EN: a zero seed is replaced by 1 so the LFSR cannot lock up.
module lfsr_multi_stage #(
    parameter int               WIDTH = 32,
    parameter int               STEPS = 32,
    parameter logic [WIDTH-1:0] TAPS  = 32'h80200003
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] lfsr_out
);

    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    typedef enum logic {
        LOAD,
        RUN
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] counter;
    logic [WIDTH-1:0] current_state;
    logic             feedback;
    logic [WIDTH-1:0] w_next_state;
    logic [WIDTH-1:0] w_load_value;

    assign feedback     = ^(current_state & TAPS);
    assign w_next_state = {current_state[WIDTH-2:0], feedback};

`ifdef LFSR_ZERO_GUARD_EN
    assign w_load_value = (seed == '0) ? WIDTH'(1) : seed;
`else
    assign w_load_value = seed;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= LOAD;
            counter       <= '0;
            current_state <= '0;
            lfsr_out      <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    current_state <= w_load_value;
                    counter       <= '0;
                    r_state       <= RUN;
                end
                RUN: begin
                    current_state <= w_next_state;
                    // The published value is the state after this edge's shift, not before it.
                    if (counter == LAST_STEP) begin
                        counter  <= '0;
                        lfsr_out <= w_next_state;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_multi_stage.sv
// Directed bench for lfsr_multi_stage: seeding, shift sequence, block output timing, lock-up, async reset and seed isolation.
module tb_lfsr_multi_stage;

    logic        clk;
    logic        rst;
    logic [31:0] seed;
    logic [31:0] lfsr_out;

    int checks = 0;
    int errors = 0;

    lfsr_multi_stage dut (
        .clk      (clk),
        .rst      (rst),
        .seed     (seed),
        .lfsr_out (lfsr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_shift(input logic [31:0] s);
        logic fb;
        fb = s[31] ^ s[21] ^ s[1] ^ s[0];
        return {s[30:0], fb};
    endfunction

    function automatic logic [31:0] model_n(input logic [31:0] s, input int n);
        logic [31:0] v;
        v = s;
        for (int i = 0; i < n; i++) v = model_shift(v);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Applies reset with the given seed and releases it between edges; the next edge is the load edge.
    task automatic do_reset(input logic [31:0] s);
        @(negedge clk);
        rst  = 1'b0;
        seed = s;
        #10;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst  = 1'b0;
        seed = 32'h1234FADC;
        #1;
        checks++;
        if (lfsr_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_out: actual %h required 00000000", lfsr_out);
        end
        checks++;
        if (dut.current_state !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: actual %h required 00000000", dut.current_state);
        end
        checks++;
        if (dut.counter !== 5'd0) begin
            errors++;
            $display("FAIL reset_counter: actual %0d required 0", dut.counter);
        end
    endtask

    task automatic test_seed_sequence();
        logic [31:0] exp_out;
        logic [31:0] m32;
        logic [31:0] m64;
        m32 = model_n(32'h1234FADC, 32);
        m64 = model_n(32'h1234FADC, 64);
        do_reset(32'h1234FADC);
        step();
        checks++;
        if (dut.current_state !== 32'h1234FADC || dut.counter !== 5'd0) begin
            errors++;
            $display("FAIL load_edge: actual %h/%0d required 1234FADC/0", dut.current_state, dut.counter);
        end
        step();
        checks++;
        if (dut.current_state !== 32'h2469F5B9 || dut.counter !== 5'd1) begin
            errors++;
            $display("FAIL shift1: actual %h/%0d required 2469F5B9/1", dut.current_state, dut.counter);
        end
        step();
        checks++;
        if (dut.current_state !== 32'h48D3EB72 || dut.counter !== 5'd2) begin
            errors++;
            $display("FAIL shift2: actual %h/%0d required 48D3EB72/2", dut.current_state, dut.counter);
        end
        for (int k = 4; k <= 65; k++) begin
            step();
            exp_out = (k < 33) ? 32'h0 : ((k < 65) ? m32 : m64);
            checks++;
            if (lfsr_out !== exp_out) begin
                errors++;
                $display("FAIL block_out edge %0d: actual %h required %h", k, lfsr_out, exp_out);
            end
            if (k == 33 || k == 65) begin
                checks++;
                if (dut.counter !== 5'd0) begin
                    errors++;
                    $display("FAIL block_wrap edge %0d: actual %0d required 0", k, dut.counter);
                end
            end
        end
    endtask

    task automatic check_seq_one(input string name);
        logic [31:0] exp_seq [4];
        exp_seq[0] = 32'h00000001;
        exp_seq[1] = 32'h00000003;
        exp_seq[2] = 32'h00000006;
        exp_seq[3] = 32'h0000000D;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (dut.current_state !== exp_seq[i]) begin
                errors++;
                $display("FAIL %s[%0d]: actual %h required %h", name, i, dut.current_state, exp_seq[i]);
            end
        end
    endtask

    task automatic test_seed_one();
        do_reset(32'h00000001);
        check_seq_one("seed_one");
    endtask

    task automatic test_zero_seed();
        do_reset(32'h00000000);
`ifdef LFSR_ZERO_GUARD_EN
        check_seq_one("zero_guard");
`else
        for (int i = 0; i < 100; i++) begin
            step();
            checks++;
            if (dut.current_state !== 32'h0 || lfsr_out !== 32'h0) begin
                errors++;
                $display("FAIL zero_lock cycle %0d: actual %h/%h required 0/0", i, dut.current_state, lfsr_out);
            end
        end
`endif
    endtask

    task automatic test_async_reset();
        do_reset(32'hCAFE0001);
        step();
        for (int i = 0; i < 42; i++) step();
        checks++;
        if (dut.counter !== 5'd10 || lfsr_out !== model_n(32'hCAFE0001, 32)) begin
            errors++;
            $display("FAIL pre_reset: actual %0d/%h required 10/%h", dut.counter, lfsr_out, model_n(32'hCAFE0001, 32));
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (dut.counter !== 5'd0 || dut.current_state !== 32'h0 || lfsr_out !== 32'h0) begin
            errors++;
            $display("FAIL async_clear: actual %0d/%h/%h required 0/0/0", dut.counter, dut.current_state, lfsr_out);
        end
        seed = 32'h1234FADC;
        @(negedge clk);
        rst = 1'b1;
        step();
        checks++;
        if (dut.current_state !== 32'h1234FADC || dut.counter !== 5'd0) begin
            errors++;
            $display("FAIL reload: actual %h/%0d required 1234FADC/0", dut.current_state, dut.counter);
        end
        step();
        checks++;
        if (dut.current_state !== 32'h2469F5B9 || dut.counter !== 5'd1) begin
            errors++;
            $display("FAIL restart: actual %h/%0d required 2469F5B9/1", dut.current_state, dut.counter);
        end
    endtask

    task automatic test_seed_change();
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'h2469F5B9;
        exp_seq[1] = 32'h48D3EB72;
        exp_seq[2] = model_n(32'h1234FADC, 3);
        do_reset(32'h1234FADC);
        step();
        seed = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (dut.current_state !== exp_seq[i]) begin
                errors++;
                $display("FAIL seed_change[%0d]: actual %h required %h", i, dut.current_state, exp_seq[i]);
            end
        end
        for (int k = 5; k <= 33; k++) step();
        checks++;
        if (lfsr_out !== model_n(32'h1234FADC, 32)) begin
            errors++;
            $display("FAIL seed_change_out: actual %h required %h", lfsr_out, model_n(32'h1234FADC, 32));
        end
    endtask

    initial begin
        rst  = 1'b1;
        seed = 32'h0;
        #2;
        test_reset();
        test_seed_sequence();
        test_seed_one();
        test_zero_seed();
        test_async_reset();
        test_seed_change();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
